// File: rtl/sample_frame_sequencer.sv
// Locks onto SYNC_BYTE and labels each following byte with its channel; 1-cycle strobe latency, no backpressure.
// Optional FRAME_CHECKSUM_EN: frame ends with an XOR check byte, adding a CHECK state and the frame_err pulse.
module sample_frame_sequencer #(
    parameter int                     NUM_CHANNELS   = 14,
    parameter int                     SAMPLE_BITS    = 8,
    parameter logic [SAMPLE_BITS-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                     TIMEOUT_CYCLES = 1024,
    parameter int                     CH_BITS        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ena,
    input  logic [SAMPLE_BITS-1:0] byte_in,
    input  logic                   byte_valid,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic [CH_BITS-1:0]     sample_ch,
    output logic                   sample_valid,
    output logic                   frame_done,
    output logic                   sync_lost,
    output logic                   locked,
`ifdef FRAME_CHECKSUM_EN
    output logic                   frame_err,
`endif
    output logic [15:0]            frame_count
);

    localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(NUM_CHANNELS - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT,
`ifdef FRAME_CHECKSUM_EN
        CHECK,
`endif
        DATA
    } state_t;

    state_t             state, state_nxt;
    logic [CH_BITS-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               vld_nxt, done_nxt, lost_nxt, load;
`ifdef FRAME_CHECKSUM_EN
    logic [SAMPLE_BITS-1:0] csum, csum_nxt;
    logic                   err_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmr_nxt   = tmr;
        vld_nxt   = 1'b0;
        done_nxt  = 1'b0;
        lost_nxt  = 1'b0;
        load      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_nxt  = csum;
        err_nxt   = 1'b0;
`endif
        if (ena) begin
            case (state)
                HUNT: begin
                    if (byte_valid && byte_in == SYNC_BYTE) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        tmr_nxt   = '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_nxt  = '0;
`endif
                    end
                end
                DATA: begin
                    // A sync value inside a frame is plain data; only the count ends the frame.
                    if (byte_valid) begin
                        load    = 1'b1;
                        vld_nxt = 1'b1;
                        tmr_nxt = '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_nxt = csum ^ byte_in;
`endif
                        if (cnt == LAST_CH) begin
                            cnt_nxt   = '0;
`ifdef FRAME_CHECKSUM_EN
                            state_nxt = CHECK;
`else
                            state_nxt = HUNT;
                            done_nxt  = 1'b1;
`endif
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CHECK: begin
                    if (byte_valid) begin
                        state_nxt = HUNT;
                        tmr_nxt   = '0;
                        if (byte_in == csum) done_nxt = 1'b1;
                        else                 err_nxt  = 1'b1;
                    end
                end
`endif
                default: state_nxt = HUNT;
            endcase

            // An accepted byte always beats the timeout, so only idle cycles advance the timer.
            if (state != HUNT && !byte_valid) begin
                if (tmr == TMR_LAST) begin
                    state_nxt = HUNT;
                    lost_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HUNT;
            cnt          <= '0;
            tmr          <= '0;
            sample_out   <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            sync_lost    <= 1'b0;
            frame_count  <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum         <= '0;
            frame_err    <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            tmr          <= tmr_nxt;
            sample_valid <= vld_nxt;
            frame_done   <= done_nxt;
            sync_lost    <= lost_nxt;
            if (load) begin
                sample_out <= byte_in;
                sample_ch  <= cnt;
            end
            if (done_nxt) frame_count <= frame_count + 16'd1;
`ifdef FRAME_CHECKSUM_EN
            csum         <= csum_nxt;
            frame_err    <= err_nxt;
`endif
        end
    end

    assign locked = (state != HUNT);

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// Bench for sample_frame_sequencer: directed scenarios plus a random byte stream checked against a frame-level model.
module tb_sample_frame_sequencer;

    localparam int NCH = 14;
    localparam int TO  = 1024;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset, ena, byte_valid;
    logic [7:0]  byte_in;
    logic [7:0]  sample_out;
    logic [3:0]  sample_ch;
    logic        sample_valid, frame_done, sync_lost, locked;
    logic [15:0] frame_count;
`ifdef FRAME_CHECKSUM_EN
    logic        frame_err;
`endif

    sample_frame_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .sample_out   (sample_out),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .sync_lost    (sync_lost),
        .locked       (locked),
`ifdef FRAME_CHECKSUM_EN
        .frame_err    (frame_err),
`endif
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int val; } smp_t;

    int   tests = 0;
    int   fails = 0;
    smp_t got_q[$];
    smp_t exp_q[$];
    int   got_done, got_lost, got_err, bad_align;
    int   exp_done, exp_lost, exp_err;
    logic [15:0] exp_count;

    // Frame-level model: hunting / position in frame / idle gap since last byte.
    bit          hunting;
    int          pos, gap;
    logic [7:0]  m_csum;

    always @(negedge clk) begin
        if (!reset) begin
            if (sample_valid) got_q.push_back('{int'(sample_ch), int'(sample_out)});
            if (frame_done) got_done++;
            if (sync_lost) got_lost++;
`ifdef FRAME_CHECKSUM_EN
            if (frame_err) got_err++;
`else
            if (frame_done && !(sample_valid && sample_ch == 4'(NCH - 1))) bad_align++;
`endif
        end
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        got_done = 0; got_lost = 0; got_err = 0; bad_align = 0;
        exp_done = 0; exp_lost = 0; exp_err = 0;
    endtask

    task automatic cyc(input logic e, input logic v, input logic [7:0] b);
        ena = e; byte_valid = v; byte_in = b;
        @(posedge clk); #1;
        if (e) begin
            if (v) begin
                if (hunting) begin
                    if (b == SYNC) begin hunting = 0; pos = 0; gap = 0; m_csum = 8'h00; end
                end else if (pos < NCH) begin
                    exp_q.push_back('{pos, int'(b)});
                    m_csum ^= b;
                    pos++;
                    gap = 0;
`ifndef FRAME_CHECKSUM_EN
                    if (pos == NCH) begin hunting = 1; exp_done++; exp_count++; end
`endif
                end else begin
                    hunting = 1;
                    if (b == m_csum) begin exp_done++; exp_count++; end
                    else exp_err++;
                end
            end else if (!hunting) begin
                gap++;
                if (gap == TO) begin hunting = 1; exp_lost++; end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_check();
`ifdef FRAME_CHECKSUM_EN
        send(m_csum);
`endif
    endtask

    task automatic do_reset();
        ena = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hunting = 1; pos = 0; gap = 0; m_csum = 8'h00; exp_count = 16'h0;
    endtask

    task automatic test_reset();
        byte_in = 8'($urandom); byte_valid = 1'b1; ena = 1'b1;
        reset = 1'b1;
        #3;
        tests++;
        if ({sample_out, sample_ch, sample_valid, frame_done, sync_lost, locked} !== 16'h0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0",
                {sample_out, sample_ch, sample_valid, frame_done, sync_lost, locked});
        end
        tests++;
        if (frame_count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h want 0", frame_count); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_sync_lock();
        clear_obs();
        send(8'h00); send(8'h11);
        tests++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_hunt: got %b want 0", locked); end
        send(SYNC);
        tests++;
        if (locked !== 1'b1) begin fails++; $display("FAIL lock_data: got %b want 1", locked); end
        for (int i = 1; i <= NCH; i++) send(8'(i));
        send_check();
        idle(2);
        tests++;
        if (got_q.size() !== NCH) begin fails++; $display("FAIL sync_strobes: got %0d want %0d", got_q.size(), NCH); end
        for (int i = 0; i < got_q.size() && i < NCH; i++) begin
            tests++;
            if (got_q[i].ch !== i || got_q[i].val !== i + 1) begin
                fails++; $display("FAIL sync_sample%0d: got ch%0d/%h want ch%0d/%h", i, got_q[i].ch, got_q[i].val, i, i + 1);
            end
        end
        tests++;
        if (got_done !== 1 || bad_align !== 0) begin
            fails++; $display("FAIL sync_done: got %0d (misaligned %0d) want 1 (0)", got_done, bad_align);
        end
        tests++;
        if (frame_count !== 16'd1 || locked !== 1'b0) begin
            fails++; $display("FAIL sync_after: count %0d locked %b want 1 0", frame_count, locked);
        end
    endtask

    task automatic test_embedded_sync();
        clear_obs();
        send(SYNC); send(SYNC);
        for (int i = 2; i <= NCH; i++) send(8'(i));
        send_check();
        idle(2);
        tests++;
        if (got_q.size() !== NCH || got_q[0].ch !== 0 || got_q[0].val !== 32'hA5 || got_q[NCH-1].ch !== NCH - 1) begin
            fails++; $display("FAIL embed_sync: size %0d first ch%0d/%h want %0d ch0/a5", got_q.size(),
                got_q[0].ch, got_q[0].val, NCH);
        end
        tests++;
        if (got_done !== 1 || frame_count !== exp_count) begin
            fails++; $display("FAIL embed_done: done %0d count %0d want 1 %0d", got_done, frame_count, exp_count);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] cnt0;
        clear_obs();
        cnt0 = frame_count;
        send(SYNC); send(8'h01); send(8'h02);
        idle(TO - 1);
        tests++;
        if (locked !== 1'b1 || got_lost !== 0) begin
            fails++; $display("FAIL timeout_early: locked %b lost %0d want 1 0", locked, got_lost);
        end
        idle(3);
        tests++;
        if (got_q.size() !== 2 || got_lost !== 1 || locked !== 1'b0 || frame_count !== cnt0) begin
            fails++; $display("FAIL timeout_abort: strobes %0d lost %0d locked %b count %0d want 2 1 0 %0d",
                got_q.size(), got_lost, locked, frame_count, cnt0);
        end
        send(SYNC); send(8'h01);
        idle(TO - 1);
        for (int i = 2; i <= NCH; i++) send(8'(i));
        send_check();
        idle(2);
        tests++;
        if (got_lost !== 1 || got_done !== 1 || got_q.size() !== 2 + NCH || frame_count !== exp_count) begin
            fails++; $display("FAIL timeout_byte_wins: lost %0d done %0d strobes %0d count %0d want 1 1 %0d %0d",
                got_lost, got_done, got_q.size(), frame_count, 2 + NCH, exp_count);
        end
    endtask

    task automatic test_ena_gating();
        clear_obs();
        send(SYNC);
        for (int i = 1; i <= 5; i++) send(8'(i));
        for (int i = 0; i < 2000; i++) cyc(1'b0, 1'b1, 8'($urandom));
        tests++;
        if (got_q.size() !== 5 || got_lost !== 0 || locked !== 1'b1) begin
            fails++; $display("FAIL ena_hold: strobes %0d lost %0d locked %b want 5 0 1", got_q.size(), got_lost, locked);
        end
        for (int i = 6; i <= NCH; i++) send(8'(i));
        send_check();
        idle(2);
        for (int i = 0; i < got_q.size() && i < NCH; i++) begin
            tests++;
            if (got_q[i].ch !== i || got_q[i].val !== i + 1) begin
                fails++; $display("FAIL ena_sample%0d: got ch%0d/%h want ch%0d/%h", i, got_q[i].ch, got_q[i].val, i, i + 1);
            end
        end
        tests++;
        if (got_q.size() !== NCH || got_done !== 1) begin
            fails++; $display("FAIL ena_resume: strobes %0d done %0d want %0d 1", got_q.size(), got_done, NCH);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        send(SYNC);
        for (int i = 1; i <= 5; i++) send(8'(i));
        idle(1);
        do_reset();
        tests++;
        if ({sample_out, sample_ch, sample_valid, locked} !== 14'h0 || frame_count !== 16'h0) begin
            fails++; $display("FAIL midreset_state: out %h ch %0d vld %b locked %b count %0d want all 0",
                sample_out, sample_ch, sample_valid, locked, frame_count);
        end
        idle(3);
        tests++;
        if (got_done !== 0 || got_lost !== 0) begin
            fails++; $display("FAIL midreset_pulses: done %0d lost %0d want 0 0", got_done, got_lost);
        end
        send(SYNC);
        for (int i = 1; i <= NCH; i++) send(8'(i));
        send_check();
        idle(2);
        tests++;
        if (frame_count !== 16'd1 || got_done !== 1) begin
            fails++; $display("FAIL midreset_frame: count %0d done %0d want 1 1", frame_count, got_done);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            send(SYNC);
            for (int i = 0; i < NCH; i++) send(8'($urandom));
            send_check();
        end
        idle(2);
        tests++;
        if (got_q.size() !== 3 * NCH || got_done !== 3 || frame_count !== exp_count) begin
            fails++; $display("FAIL b2b: strobes %0d done %0d count %0d want %0d 3 %0d",
                got_q.size(), got_done, frame_count, 3 * NCH, exp_count);
        end
        start = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].ch !== exp_q[i].ch || got_q[i].val !== exp_q[i].val) start++;
        tests++;
        if (start !== 0) begin fails++; $display("FAIL b2b_data: got %0d bad samples want 0", start); end
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        logic [15:0] cnt0;
        clear_obs();
        send(SYNC);
        for (int i = 1; i <= NCH; i++) send(8'(i));
        send(8'h0F);
        idle(2);
        tests++;
        if (got_done !== 1 || got_err !== 0 || frame_count !== exp_count) begin
            fails++; $display("FAIL csum_good: done %0d err %0d count %0d want 1 0 %0d", got_done, got_err, frame_count, exp_count);
        end
        cnt0 = frame_count;
        send(SYNC);
        for (int i = 1; i <= NCH; i++) send(8'(i));
        send(8'h00);
        idle(2);
        tests++;
        if (got_done !== 1 || got_err !== 1 || frame_count !== cnt0 || got_q.size() !== 2 * NCH) begin
            fails++; $display("FAIL csum_bad: done %0d err %0d count %0d strobes %0d want 1 1 %0d %0d",
                got_done, got_err, frame_count, got_q.size(), cnt0, 2 * NCH);
        end
    endtask
`endif

    task automatic test_random();
        int longs = 0;
        int r;
        clear_obs();
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                r = $urandom_range(0, 255);
                send((8'(r) == SYNC) ? 8'h5A : 8'(r));
            end
            send(SYNC);
            for (int k = 0; k < NCH; k++) begin
                r = $urandom_range(0, 99);
                if (r < 8) idle($urandom_range(1, 4));
                else if (r < 12) begin
                    for (int j = 0; j < $urandom_range(1, 3); j++) cyc(1'b0, 1'($urandom), 8'($urandom));
                end else if (r == 12 && longs < 3) begin
                    longs++;
                    idle(TO + $urandom_range(0, 2));
                end
                send(($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom));
            end
`ifdef FRAME_CHECKSUM_EN
            send(($urandom_range(0, 4) == 0) ? 8'($urandom) : m_csum);
`endif
        end
        idle(2);
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL rand_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i].ch !== exp_q[i].ch || got_q[i].val !== exp_q[i].val) begin
                fails++; $display("FAIL rand_sample%0d: got ch%0d/%h want ch%0d/%h", i,
                    got_q[i].ch, got_q[i].val, exp_q[i].ch, exp_q[i].val);
            end
        end
        tests++;
        if (got_done !== exp_done || got_lost !== exp_lost || got_err !== exp_err ||
            frame_count !== exp_count || bad_align !== 0) begin
            fails++; $display("FAIL rand_events: done %0d lost %0d err %0d count %0d misaligned %0d want %0d %0d %0d %0d 0",
                got_done, got_lost, got_err, frame_count, bad_align, exp_done, exp_lost, exp_err, exp_count);
        end
    endtask

    initial begin
        reset = 1'b0; ena = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        hunting = 1; pos = 0; gap = 0; m_csum = 8'h00; exp_count = 16'h0;
        clear_obs();
        #2;
        test_reset();
        test_sync_lock();
        test_embedded_sync();
        test_timeout();
        test_ena_gating();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
